line_reverse_buffer: RTL and testbench
======================================

Name: line_reverse_buffer

Overview:
- Ping-pong BRAM line buffer in the video datapath of the tracker.
- Accepts a pixel stream one line at a time and plays each completed line back last-pixel-first, producing a horizontally mirrored stream.
- The write side and the read side are the two ends of a single per-line handoff. Reading one bank overlaps with writing the other.
- Sits alongside the RAM-based shift-register line delays, ahead of the window/feature stages.

Parameters:
- DSIZE, 16, pixel word width.
- WDEPTH, 800, maximum line length; each of the two banks holds WDEPTH words.
- ASIZE, $clog2(WDEPTH), address / length width.

Ports:
- Clock  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Din  in  DSIZE  input pixel.
- Din_valid  in  1  Din is valid this cycle; no backpressure is provided.
- Line_len  in  ASIZE  pixels per line; latched on the first valid pixel of each line.
- Dout  out  DSIZE  reversed pixel.
- Dout_valid  out  1  Dout is valid.
- Line_done  out  1  one-cycle pulse that coincides with the last reversed pixel of a line.
- Overflow  out  1  sticky error flag; cleared only by Reset.

Behaviour:
- Reset asserted:
  - Dout=0, Dout_valid=0, Line_done=0, Overflow=0.
  - Write bank=0, write count=0, read FSM=IDLE.
  - RAM contents are not reset.
- Length latch:
  - On a Din_valid with write count=0, Line_len is captured into len_q.
  - If Line_len=0 or Line_len>WDEPTH, len_q=WDEPTH.
  - Line_len is ignored for the rest of that line.
- Write:
  - Each Din_valid writes Din to wbank[count], then count++.
  - The write in which count reaches len_q-1 completes the line.
  - On completion, count returns to 0.
- Handoff when the read FSM is IDLE (or finishing its last word in the same cycle):
  - The completed bank, with its len_q, is handed to the reader.
  - The write bank toggles.
- Handoff when the read FSM is busy (not on its last word):
  - The completed line is discarded and the write bank is not toggled.
  - Overflow is set to 1 and stays at 1.
- Read FSM:
  - IDLE -> READ on handoff. The read address is loaded with len-1.
  - READ issues one read per cycle, decrementing the address.
  - READ -> IDLE after issuing address 0, unless a handoff occurs in that same cycle. In that case the FSM reloads for the other bank with no gap.
- Latency and pipeline:
  - RAM read is registered, followed by an output register.
  - The first reversed word appears with Dout_valid=1 two rising edges after the edge that sampled the last input pixel.
  - The remaining len-1 words follow on consecutive cycles with no gaps, whatever the input valid pattern was.
- Line_done is high in the same cycle as the Dout carrying the word from address 0.
- Dout holds its last value when Dout_valid=0.
- Simultaneous events:
  - A write to one bank and a read of the other in the same cycle is always legal.
  - Reads and writes never target the same bank in the same cycle.
- Reset mid-line or mid-readout:
  - The partial line or remaining readout is abandoned.
  - Nothing further is output from it.
  - The next line after deassertion is processed normally.

Test Plan:
- Line_len=4, Din=1,2,3,4 on consecutive cycles -> Dout=4,3,2,1 on 4 consecutive cycles, first one 2 edges after the edge that samples Din=4; Line_done high with 1; Overflow=0.
- Line_len=800, continuous ramp 0..1599 (two lines) -> Dout=799..0 then 1599..800 with no gap between lines; two Line_done pulses; Overflow=0.
- Line_len=8, Din_valid every other cycle, Din=10..17 -> Dout=17..10 on 8 contiguous cycles.
- Line_len=8 then 2, sent back to back, then a third line of 8 (Din=30..37) sent after a 10-cycle pause -> first line output 8 words; second line dropped and Overflow=1; third line outputs 37..30; Overflow stays 1.
- Line_len=800, Reset pulsed at pixel 300 -> Dout_valid stays 0 and all outputs return to reset values; the next 800-pixel line (0..799) outputs 799..0 correctly.
- Line_len=0, then Line_len=1000, each with an 800-pixel ramp -> both treated as 800; 800 reversed words per line.

Source files
------------

// File: rtl/line_reverse_buffer.sv
// Ping-pong line buffer: writes one bank while the other is played back
// last-pixel-first, giving a horizontally mirrored pixel stream.
module line_reverse_buffer #(
  parameter int DSIZE  = 16,
  parameter int WDEPTH = 800,
  parameter int ASIZE  = $clog2(WDEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [DSIZE-1:0] Din,
  input  logic             Din_valid,
  input  logic [ASIZE-1:0] Line_len,
  output logic [DSIZE-1:0] Dout,
  output logic             Dout_valid,
  output logic             Line_done,
  output logic             Overflow
);

  typedef enum logic {IDLE, READ} state_t;

  logic [DSIZE-1:0] mem0 [WDEPTH];
  logic [DSIZE-1:0] mem1 [WDEPTH];

  // write side
  logic             wbank_q;
  logic [ASIZE-1:0] wcnt_q, len_q;
  logic             ovf_q;
  logic [ASIZE-1:0] len_clamp, len_eff;
  logic             wr_last, accept, drop;

  // read side
  state_t           state_q;
  logic [ASIZE-1:0] raddr_q;
  logic             rbank_q;
  logic             rd_vld_q, rd_last_q;
  logic [DSIZE-1:0] rdata_q;
  logic             rd_last_issue;

  // output stage
  logic [DSIZE-1:0] dout_q;
  logic             dout_vld_q, done_q;

  always_comb begin
    len_clamp = Line_len;
    if (Line_len == '0 || Line_len > ASIZE'(WDEPTH)) len_clamp = ASIZE'(WDEPTH);
    // the first pixel of a line uses the length presented with it
    len_eff = (wcnt_q == '0) ? len_clamp : len_q;
  end

  assign wr_last       = Din_valid && (wcnt_q == len_eff - ASIZE'(1));
  assign rd_last_issue = (state_q == READ) && (raddr_q == '0);
  // reader may take a new line when idle or issuing its final address
  assign accept        = wr_last && ((state_q == IDLE) || rd_last_issue);
  assign drop          = wr_last && !accept;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wbank_q <= 1'b0;
      wcnt_q  <= '0;
      len_q   <= ASIZE'(WDEPTH);
      ovf_q   <= 1'b0;
    end else if (Din_valid) begin
      if (wcnt_q == '0) len_q <= len_clamp;
      wcnt_q <= wr_last ? '0 : wcnt_q + ASIZE'(1);
      if (accept) wbank_q <= ~wbank_q;
      if (drop)   ovf_q   <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Din_valid) begin
      if (wbank_q) mem1[wcnt_q] <= Din;
      else         mem0[wcnt_q] <= Din;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      raddr_q   <= '0;
      rbank_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_vld_q  <= (state_q == READ);
      rd_last_q <= rd_last_issue;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= READ;
            raddr_q <= len_eff - ASIZE'(1);
            rbank_q <= wbank_q;
          end
        end
        READ: begin
          if (accept) begin
            raddr_q <= len_eff - ASIZE'(1);
            rbank_q <= wbank_q;
          end else if (raddr_q == '0) begin
            state_q <= IDLE;
          end else begin
            raddr_q <= raddr_q - ASIZE'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (state_q == READ) rdata_q <= rbank_q ? mem1[raddr_q] : mem0[raddr_q];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      dout_vld_q <= rd_vld_q;
      done_q     <= rd_vld_q && rd_last_q;
      if (rd_vld_q) dout_q <= rdata_q;
    end
  end

  assign Dout       = dout_q;
  assign Dout_valid = dout_vld_q;
  assign Line_done  = done_q;
  assign Overflow   = ovf_q;

endmodule

// File: tb/tb_line_reverse_buffer.sv
// Bench for line_reverse_buffer: a cycle-timed model of accepted lines
// predicts every output word, its cycle, Line_done and Overflow.
module tb_line_reverse_buffer;

  localparam int DSIZE  = 16;
  localparam int WDEPTH = 800;
  localparam int ASIZE  = $clog2(WDEPTH);

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic [DSIZE-1:0] Din = '0;
  logic             Din_valid = 1'b0;
  logic [ASIZE-1:0] Line_len = '0;
  logic [DSIZE-1:0] Dout;
  logic             Dout_valid, Line_done, Overflow;

  line_reverse_buffer #(.DSIZE(DSIZE), .WDEPTH(WDEPTH), .ASIZE(ASIZE)) dut (
    .Clock(Clock), .Reset(Reset), .Din(Din), .Din_valid(Din_valid),
    .Line_len(Line_len), .Dout(Dout), .Dout_valid(Dout_valid),
    .Line_done(Line_done), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  int edge_cnt = 0;
  always @(posedge Clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int               edge_n;
    logic [DSIZE-1:0] d;
    bit               done;
  } exp_t;

  exp_t             exp_q[$];
  logic [DSIZE-1:0] wbuf[$];
  int               wcnt = 0, mlen = WDEPTH;
  int               last_issue = -1000000;
  bit               m_ovf = 1'b0;
  logic [DSIZE-1:0] last_dout = '0;
  int               vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, expv, edge_cnt);
    end
  endtask

  task automatic check_outputs();
    if (exp_q.size() != 0 && exp_q[0].edge_n == edge_cnt) begin
      chk("dout_valid", {31'b0, Dout_valid}, 32'd1);
      chk("dout", {16'b0, Dout}, {16'b0, exp_q[0].d});
      chk("line_done", {31'b0, Line_done}, {31'b0, exp_q[0].done});
      last_dout = exp_q[0].d;
      void'(exp_q.pop_front());
    end else begin
      chk("valid_idle", {31'b0, Dout_valid}, 32'd0);
      chk("done_idle", {31'b0, Line_done}, 32'd0);
      chk("dout_hold", {16'b0, Dout}, {16'b0, last_dout});
    end
    chk("overflow", {31'b0, Overflow}, {31'b0, m_ovf});
  endtask

  // pixel sampled at edge n: a completed line is accepted when the reader's
  // last read issue is no later than n, and then plays out from edge n+2
  task automatic model_write(input int n, input logic [DSIZE-1:0] d, input int l);
    if (wcnt == 0) mlen = (l == 0 || l > WDEPTH) ? WDEPTH : l;
    wbuf.push_back(d);
    wcnt++;
    if (wcnt == mlen) begin
      if (last_issue <= n) begin
        for (int k = 0; k < mlen; k++)
          exp_q.push_back('{n + 2 + k, wbuf[mlen-1-k], (k == mlen-1)});
        last_issue = n + mlen;
      end else begin
        m_ovf = 1'b1;
      end
      wcnt = 0;
      wbuf.delete();
    end
  endtask

  task automatic step(input bit v, input logic [DSIZE-1:0] d, input int l);
    @(negedge Clock);
    check_outputs();
    Din_valid = v;
    Din       = d;
    Line_len  = ASIZE'(l);
    if (v) model_write(edge_cnt + 1, d, l);
  endtask

  task automatic reset_pulse(input int cycles);
    @(negedge Clock);
    check_outputs();
    Reset = 1'b1;
    Din_valid = 1'b0;
    exp_q.delete();
    wbuf.delete();
    wcnt = 0;
    m_ovf = 1'b0;
    last_dout = '0;
    last_issue = -1000000;
    repeat (cycles) begin
      @(negedge Clock);
      check_outputs();
    end
    Reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) step(0, '0, 0);
    chk("drain_timeout", exp_q.size(), 32'd0);
    repeat (3) step(0, '0, 0);
  endtask

  task automatic ramp(input int first, input int count, input int l);
    for (int i = 0; i < count; i++) step(1, DSIZE'(first + i), l);
  endtask

  initial begin
    reset_pulse(3);

    // short line, consecutive pixels
    ramp(1, 4, 4);
    drain();

    // two full-length lines back to back, no gap expected in playback
    ramp(0, 1600, 800);
    drain();

    // sparse input valid, contiguous output
    for (int i = 0; i < 8; i++) begin
      step(1, DSIZE'(10 + i), 8);
      step(0, '0, 8);
    end
    drain();

    // second line arrives while reader busy: dropped, Overflow sticks
    ramp(20, 8, 8);
    ramp(40, 2, 2);
    repeat (10) step(0, '0, 0);
    ramp(30, 8, 8);
    drain();

    // reset mid-line abandons it; next line is normal
    ramp(0, 300, 800);
    reset_pulse(2);
    repeat (5) step(0, '0, 0);
    ramp(0, 800, 800);
    drain();

    // randomized lines: random length, gaps, data and junk Line_len mid-line
    for (int ln = 0; ln < 25; ln++) begin
      int len = $urandom_range(1, 24);
      int sent = 0;
      while (sent < len) begin
        if ($urandom_range(0, 9) < 7) begin
          step(1, DSIZE'($urandom), (sent == 0) ? len : int'($urandom_range(0, 1023)));
          sent++;
        end else begin
          step(0, DSIZE'($urandom), int'($urandom_range(0, 1023)));
        end
      end
      repeat ($urandom_range(0, 30)) step(0, '0, 0);
    end
    drain();

    // out-of-range lengths clamp to the full line
    reset_pulse(2);
    ramp(100, 800, 0);
    ramp(2000, 800, 1000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
